// File: rtl/aximm_rand_arb.sv
// Round-robin sequencer sharing one LFSR generator between the write-data
// generator (wr) and the read-data checker (rd); streams seeded words over valid/ready.
module aximm_rand_arb #(
    parameter int LEADER_MODE = 1,
    localparam int W = 40 * LEADER_MODE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_req,
    input  logic [W-1:0] wr_seed,
    input  logic [7:0]   wr_len,
    input  logic         wr_ready,
    input  logic         rd_req,
    input  logic [W-1:0] rd_seed,
    input  logic [7:0]   rd_len,
    input  logic         rd_ready,
    input  logic [W-1:0] lfsr_dout,
    output logic         lfsr_ena,
    output logic [W-1:0] lfsr_seed,
    output logic         wr_gnt,
    output logic         rd_gnt,
    output logic         wr_valid,
    output logic         rd_valid,
    output logic [W-1:0] rand_data,
    output logic         wr_done,
    output logic         rd_done,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_e;

    state_e       state_q;
    logic [W-1:0] seed_q;
    logic [7:0]   cnt_q;
    logic [1:0]   gnt_q;      // bit 0 = wr, bit 1 = rd
    logic [1:0]   done_q;
    logic         last_rd_q;  // 1 when rd was the last requester served

    logic pick_rd_d;
    logic sel_ready;
    logic in_stream;
    logic stall;

    // On a tie the requester that was not served last wins.
    assign pick_rd_d = rd_req & (~wr_req | ~last_rd_q);

    assign sel_ready = gnt_q[0] ? wr_ready : rd_ready;
    assign in_stream = (state_q == STREAM);
    assign stall     = in_stream & ~sel_ready;

    // A stall reloads the word on display so the generator does not advance.
    assign lfsr_ena  = (state_q == LOAD) | stall;
    assign lfsr_seed = (state_q == LOAD) ? seed_q :
                       stall             ? lfsr_dout : '0;

    assign wr_gnt    = gnt_q[0];
    assign rd_gnt    = gnt_q[1];
    assign wr_valid  = in_stream & gnt_q[0];
    assign rd_valid  = in_stream & gnt_q[1];
    assign rand_data = lfsr_dout;
    assign wr_done   = done_q[0];
    assign rd_done   = done_q[1];
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            seed_q    <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            last_rd_q <= 1'b1;
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (wr_req | rd_req) begin
                        gnt_q   <= pick_rd_d ? 2'b10 : 2'b01;
                        seed_q  <= pick_rd_d ? rd_seed : wr_seed;
                        cnt_q   <= pick_rd_d ? rd_len : wr_len;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    state_q <= STREAM;
                end
                STREAM: begin
                    if (sel_ready) begin
                        if (cnt_q == 8'd0) begin
                            done_q    <= gnt_q;
                            last_rd_q <= gnt_q[1];
                            gnt_q     <= '0;
                            state_q   <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aximm_rand_arb.sv
// Bench for aximm_rand_arb: a behavioural generator plus a stream-level model
// checked every cycle, with directed scenarios pinning literal values.
module tb_aximm_rand_arb;

    localparam int W = 40;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_req = 1'b0, rd_req = 1'b0;
    logic [W-1:0] wr_seed = '0, rd_seed = '0;
    logic [7:0]   wr_len = '0, rd_len = '0;
    logic         wr_ready = 1'b1, rd_ready = 1'b1;
    logic [W-1:0] lfsr_dout;
    logic         lfsr_ena;
    logic [W-1:0] lfsr_seed;
    logic         wr_gnt, rd_gnt, wr_valid, rd_valid, wr_done, rd_done, busy;
    logic [W-1:0] rand_data;

    int tests = 0;
    int fails = 0;
    int cyc;

    always #5 clk = ~clk;

    aximm_rand_arb #(.LEADER_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_seed(wr_seed), .wr_len(wr_len), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_seed(rd_seed), .rd_len(rd_len), .rd_ready(rd_ready),
        .lfsr_dout(lfsr_dout), .lfsr_ena(lfsr_ena), .lfsr_seed(lfsr_seed),
        .wr_gnt(wr_gnt), .rd_gnt(rd_gnt), .wr_valid(wr_valid), .rd_valid(rd_valid),
        .rand_data(rand_data), .wr_done(wr_done), .rd_done(rd_done), .busy(busy)
    );

    // 40-bit Fibonacci LFSR, taps 40/38/21/19, shifting left.
    function automatic logic [W-1:0] step(input logic [W-1:0] x);
        return {x[W-2:0], x[39] ^ x[37] ^ x[20] ^ x[18]};
    endfunction

    // Generator: load the seed when enabled, otherwise advance one step.
    logic [W-1:0] gen_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) gen_q <= '0;
        else        gen_q <= lfsr_ena ? lfsr_seed : step(gen_q);
    end
    assign lfsr_dout = gen_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stream-level model: phase 0 idle, 1 seed load, 2 streaming.
    int           m_ph = 0, m_own = 0, m_left = 0, m_len = 0, m_last = 1, m_done = -1;
    logic [W-1:0] m_word = '0, m_seed = '0;
    logic         p_wr = 1'b0, p_rd = 1'b0;
    logic [W-1:0] pres_wr[$], acc_wr[$], acc_rd[$];
    int           gnt_ord[$], gnt_cyc[$], done_wr[$], done_rd[$];

    always @(negedge clk) begin
        logic own_rdy, e_load, e_stream, e_stall;
        if (!rst_n) begin
            chk("reset_outs", {lfsr_ena, wr_gnt, rd_gnt, wr_valid, rd_valid, wr_done, rd_done, busy}, 64'd0);
            chk("reset_seed", lfsr_seed, 64'd0);
            m_ph = 0; m_last = 1; m_done = -1; p_wr = 1'b0; p_rd = 1'b0;
            pres_wr.delete(); acc_wr.delete(); acc_rd.delete();
            gnt_ord.delete(); gnt_cyc.delete(); done_wr.delete(); done_rd.delete();
        end else begin
            own_rdy  = (m_own == 0) ? wr_ready : rd_ready;
            e_load   = (m_ph == 1);
            e_stream = (m_ph == 2);
            e_stall  = e_stream && !own_rdy;
            chk("wr_gnt",   wr_gnt,   m_ph != 0 && m_own == 0);
            chk("rd_gnt",   rd_gnt,   m_ph != 0 && m_own == 1);
            chk("wr_valid", wr_valid, e_stream && m_own == 0);
            chk("rd_valid", rd_valid, e_stream && m_own == 1);
            chk("wr_done",  wr_done,  m_done == 0);
            chk("rd_done",  rd_done,  m_done == 1);
            chk("busy",     busy,     m_ph != 0);
            chk("lfsr_ena", lfsr_ena, e_load || e_stall);
            chk("lfsr_seed", lfsr_seed, e_load ? m_seed : (e_stall ? m_word : '0));
            if (e_stream) chk("rand_data", rand_data, m_word);

            if (wr_valid) pres_wr.push_back(rand_data);
            if (wr_valid && wr_ready) acc_wr.push_back(rand_data);
            if (rd_valid && rd_ready) acc_rd.push_back(rand_data);
            if (wr_gnt && !p_wr) begin gnt_ord.push_back(0); gnt_cyc.push_back(cyc); end
            if (rd_gnt && !p_rd) begin gnt_ord.push_back(1); gnt_cyc.push_back(cyc); end
            p_wr = wr_gnt; p_rd = rd_gnt;
            if (wr_done) begin done_wr.push_back(cyc); $display("[TB] wr stream done at cycle %0d", cyc); end
            if (rd_done) begin done_rd.push_back(cyc); $display("[TB] rd stream done at cycle %0d", cyc); end

            // Advance the model using the inputs that the next edge will sample.
            m_done = -1;
            case (m_ph)
                0: if (wr_req || rd_req) begin
                    m_own  = (wr_req && rd_req) ? (m_last == 1 ? 0 : 1) : (wr_req ? 0 : 1);
                    m_seed = (m_own == 1) ? rd_seed : wr_seed;
                    m_len  = (m_own == 1) ? int'(rd_len) : int'(wr_len);
                    m_ph   = 1;
                end
                1: begin m_ph = 2; m_word = m_seed; m_left = m_len + 1; end
                default: if (own_rdy) begin
                    if (m_left == 1) begin
                        m_ph = 0; m_done = m_own; m_last = m_own;
                    end else begin
                        m_left--; m_word = step(m_word);
                    end
                end
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] exp_pres[6];
        logic [63:0]  r;
        exp_pres = '{40'h1, 40'h2, 40'h2, 40'h2, 40'h4, 40'h8};

        // Single stream with request withdrawn after grant.
        wr_req = 1; wr_seed = 40'h1; wr_len = 8'd3; wr_ready = 1; rd_req = 0; rd_ready = 1;
        do_reset();
        tick(1); wr_req = 0;
        tick(9);
        chk("s1_gnt_cyc", gnt_cyc.size() > 0 ? gnt_cyc[0] : -1, 1);
        chk("s1_ngnt", gnt_ord.size(), 1);
        chk("s1_nacc", acc_wr.size(), 4);
        for (int i = 0; i < 4; i++) chk("s1_word", acc_wr.size() > i ? acc_wr[i] : '1, 64'd1 << i);
        chk("s1_done_cyc", done_wr.size() > 0 ? done_wr[0] : -1, 6);
        chk("s1_busy", busy, 0);

        // Backpressure in cycles 3-4.
        wr_req = 1; wr_seed = 40'h1; wr_len = 8'd3; wr_ready = 1;
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            tick(1);
            wr_req = 0;
            wr_ready = (c == 3 || c == 4) ? 1'b0 : 1'b1;
            if (c == 3 || c == 4) begin
                @(negedge clk);
                chk("s2_stall_ena", lfsr_ena, 1);
                chk("s2_stall_seed", lfsr_seed, 40'h2);
            end
        end
        chk("s2_npres", pres_wr.size(), 6);
        for (int i = 0; i < 6; i++) chk("s2_pres", pres_wr.size() > i ? pres_wr[i] : '1, exp_pres[i]);
        chk("s2_nacc", acc_wr.size(), 4);
        chk("s2_done_cyc", done_wr.size() > 0 ? done_wr[0] : -1, 8);

        // Tie from reset, then round-robin.
        wr_req = 1; rd_req = 1; wr_seed = 40'h5; rd_seed = 40'hA; wr_len = 0; rd_len = 0;
        wr_ready = 1; rd_ready = 1;
        do_reset();
        tick(10);
        chk("s3_ngnt_ge3", gnt_ord.size() >= 3, 1);
        chk("s3_first", gnt_ord.size() > 0 ? gnt_ord[0] : -1, 0);
        chk("s3_second", gnt_ord.size() > 1 ? gnt_ord[1] : -1, 1);
        chk("s3_third", gnt_ord.size() > 2 ? gnt_ord[2] : -1, 0);
        chk("s3_rd_gnt_cyc", gnt_cyc.size() > 1 ? gnt_cyc[1] : -1, 4);
        chk("s3_wr_word", acc_wr.size() > 0 ? acc_wr[0] : '1, 40'h5);
        chk("s3_rd_word", acc_rd.size() > 0 ? acc_rd[0] : '1, 40'hA);
        wr_req = 0; rd_req = 0;

        // Feedback crossing on a 20-beat stream.
        wr_req = 1; wr_seed = 40'h1; wr_len = 8'd19;
        do_reset();
        tick(1); wr_req = 0;
        tick(25);
        chk("s4_nacc", acc_wr.size(), 20);
        chk("s4_beat18", acc_wr.size() > 18 ? acc_wr[18] : '1, 40'h40000);
        chk("s4_beat19", acc_wr.size() > 19 ? acc_wr[19] : '1, 40'h80001);

        // Asynchronous reset during beat 2 of an 8-beat rd stream.
        rd_req = 1; rd_seed = 40'h123; rd_len = 8'd7;
        do_reset();
        tick(1); rd_req = 0;
        tick(3);
        #1 rst_n = 1'b0;
        #1;
        chk("s5_async_outs", {lfsr_ena, wr_gnt, rd_gnt, wr_valid, rd_valid, wr_done, rd_done, busy}, 64'd0);
        chk("s5_async_data", {lfsr_seed, rand_data}, 64'd0);
        rd_req = 1; rd_seed = 40'h3; rd_len = 8'd1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1); rd_req = 0;
        tick(8);
        chk("s5_nacc", acc_rd.size(), 2);
        chk("s5_w0", acc_rd.size() > 0 ? acc_rd[0] : '1, 40'h3);
        chk("s5_w1", acc_rd.size() > 1 ? acc_rd[1] : '1, 40'h6);
        chk("s5_ndone", done_rd.size(), 1);

        // Randomized traffic against the model.
        wr_req = 0; rd_req = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            tick(1);
            wr_req   = ($urandom_range(0, 3) != 0);
            rd_req   = ($urandom_range(0, 3) != 0);
            wr_ready = ($urandom_range(0, 3) != 0);
            rd_ready = ($urandom_range(0, 3) != 0);
            r = {$urandom, $urandom};
            wr_seed = ($urandom_range(0, 7) == 0) ? '0 : r[W-1:0];
            r = {$urandom, $urandom};
            rd_seed = ($urandom_range(0, 7) == 0) ? '0 : r[W-1:0];
            wr_len = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
            rd_len = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
            if (i == 2000) begin
                #2 rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aximm_rand_arb.md
Name: aximm_rand_arb

Overview:
- Sequencer/arbiter that shares one aximm_rand_gen LFSR between two requesters in the AXI-MM traffic example: the write-data generator (wr) and the read-data checker (rd).
- Grants the LFSR round-robin, loads the requester's seed, and streams a requested number of random words to the granted requester over a valid/ready handshake.
- Freezes the LFSR under backpressure by re-loading the current word each stalled cycle, so no sequence values are skipped.

Parameters:
- LEADER_MODE, 1, width multiplier; data width W = 40*LEADER_MODE (1=FULL, 2=HALF); must match the attached generator.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, active-low
- wr_req  in  1  write-data requester wants a stream (level)
- wr_seed  in  W  seed for the wr stream
- wr_len  in  8  wr beats minus one (0 = 1 beat, 255 = 256 beats)
- wr_ready  in  1  wr accepts the current word
- rd_req  in  1  read-checker requester wants a stream (level)
- rd_seed  in  W  seed for the rd stream
- rd_len  in  8  rd beats minus one
- rd_ready  in  1  rd accepts the current word
- lfsr_dout  in  W  generator rand_dout
- lfsr_ena  out  1  to generator ena_in
- lfsr_seed  out  W  to generator seed_in
- wr_gnt  out  1  wr owns the LFSR
- rd_gnt  out  1  rd owns the LFSR
- wr_valid  out  1  rand_data valid for wr
- rd_valid  out  1  rand_data valid for rd
- rand_data  out  W  current random word (= lfsr_dout)
- wr_done  out  1  one-cycle pulse: wr stream complete
- rd_done  out  1  one-cycle pulse: rd stream complete
- busy  out  1  state != IDLE

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous and active-low. Every register, including all outputs, clears on assertion regardless of clk. The reset values are:
  - state=IDLE
  - gnt, valid and done outputs = 0
  - lfsr_ena=0, lfsr_seed=0, busy=0
  - beat counter = 0
  - last_served = rd, so wr wins the first tie.
- State machine: IDLE -> LOAD -> STREAM -> IDLE.
- IDLE:
  - If only one req is high, that requester is selected.
  - If both are high, the requester not in last_served is selected.
  - On selection, capture that requester's seed into seed_q and its len into cnt_q, set its gnt (registered), and go to LOAD.
  - With no req, stay in IDLE.
- LOAD (1 cycle): lfsr_ena=1, lfsr_seed=seed_q. The generator holds the seed on the next cycle. Go to STREAM.
- STREAM:
  - The granted valid=1 and rand_data=lfsr_dout. The first word delivered equals the seed.
  - On valid&ready with cnt_q!=0: lfsr_ena=0 so the LFSR advances one step, and cnt_q decrements.
  - On valid&!ready (stall): lfsr_ena=1 and lfsr_seed=lfsr_dout. The word is held unchanged and the same word is re-presented next cycle.
  - On valid&ready with cnt_q==0 (last beat):
    - Next cycle: the granted done pulses for 1 cycle, gnt drops, and valid drops.
    - last_served updates to that requester, and state returns to IDLE.
    - lfsr_ena=0 on the last beat.
- Latency:
  - req seen in IDLE at cycle N -> gnt and lfsr_ena at N+1 -> first valid at N+2.
  - Last beat accepted at M -> done at M+1 -> next LOAD no earlier than M+2.
- The non-granted requester's valid and done stay 0 throughout.
- lfsr_seed=0 whenever lfsr_ena=0.
- req deassertion during LOAD or STREAM is ignored; the stream runs to completion.
- seed and len are sampled only at the IDLE->LOAD transition; later changes have no effect.
- A zero seed is passed through unchanged; the generator yields a constant 0 stream (requester responsibility).
- wr_gnt and rd_gnt are never both 1.
- Reset mid-stream: outputs clear immediately; no done pulse is issued. The generator is reloaded on the next grant.

Test Plan:
- Single stream: LEADER_MODE=1, wr_req=1, wr_seed=40'h1, wr_len=3, wr_ready=1 -> wr_gnt at cycle 1, wr_valid cycles 2-5 with data 1,2,4,8, then wr_done pulse at cycle 6, busy=0.
- Backpressure: as above with wr_ready low in cycles 3-4 -> data 1,2,2,2,4,8; lfsr_ena=1 with lfsr_seed=2 in cycles 3-4; no word is skipped or duplicated after acceptance.
- Tie and round-robin: wr_req=rd_req=1 from reset, both len=0, seeds 40'h5/40'hA -> wr served first with data 5; then rd gnt, LOAD, data A; then, with both still requesting, wr again.
- LFSR feedback crossing: seed 40'h1, len=19 -> beat 18 is 40'h40000 and beat 19 is 40'h80001.
- Mid-stream reset: assert rst_n=0 during beat 2 of an 8-beat rd stream -> all outputs 0 without a clock edge. After release, a new rd_req with seed 40'h3, len=1 delivers 3,6.
- Request withdrawal: drop wr_req right after wr_gnt with wr_len=2 -> all 3 beats are still delivered, wr_done pulses, and there is no regrant while req is low.
